hazard_controller: RTL
======================

Name: hazard_controller

Overview:
- Central hazard and stall scheduler for the 5-stage pipelined MIPS.
- Drives stall (EN) and clear (CLR) on the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Generates forwarding selects for the decode-stage comparator and the execute-stage ALU operands.
- Sequences a multi-cycle data-memory access with a wait-state FSM that freezes the pipeline until the access completes.

Parameters:
- REG_W, 5, register-specifier width.
- MEM_LATENCY, 2, extra wait cycles per data-memory access; 0 = single-cycle memory.
- CNT_W, 4, wait counter width; MEM_LATENCY must be ≤ 2^CNT_W-1.

Ports:
- CLK  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- RsD, RtD  in  REG_W  source registers in decode.
- RsE, RtE  in  REG_W  source registers in execute.
- WriteRegE, WriteRegM, WriteRegW  in  REG_W  destination registers in E, M, W.
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables in E, M, W.
- MemtoRegE, MemtoRegM  in  1  load in E, load in M.
- BranchD, JumpD, PCSrcD  in  1  branch in decode, jump in decode, branch taken.
- MemAccessM  in  1  load or store in memory stage.
- StallF, StallD  out  1  hold PC and IF/ID; StallD drives the active-low EN of IF/ID.
- StallE, StallM  out  1  hold ID/EX and EX/MEM.
- FlushD  out  1  clear IF/ID; drives CLR.
- FlushE  out  1  bubble into ID/EX.
- FlushW  out  1  bubble into MEM/WB.
- ForwardAD, ForwardBD  out  1  decode comparator operand from the M-stage ALU result.
- ForwardAE, ForwardBE  out  2  execute ALU operand select.
- MemBusy  out  1  memory FSM is in WAIT.

Behaviour:
- Clock and reset: one clock CLK; reset rst is asynchronous and active-low.
- Reset: state=IDLE, cnt=0, MemBusy=0. Other outputs are combinational from inputs and state; with all inputs 0 every output is 0.
- Forwarding, execute stage:
  - ForwardAE=2'b10 if RsE!=0 && RegWriteM && RsE==WriteRegM.
  - Else ForwardAE=2'b01 if RsE!=0 && RegWriteW && RsE==WriteRegW.
  - Else ForwardAE=2'b00. The M stage has priority over W.
  - ForwardBE is identical using RtE.
- Forwarding, decode stage: ForwardAD = RsD!=0 && RegWriteM && RsD==WriteRegM. ForwardBD is identical using RtD.
- lwstall = MemtoRegE && (RtE==RsD || RtE==RtD).
- branchstall = BranchD && ((RegWriteE && WriteRegE∈{RsD,RtD}) || (MemtoRegM && WriteRegM∈{RsD,RtD})).
- Memory FSM, states IDLE and WAIT:
  - IDLE: if MemAccessM && MEM_LATENCY!=0, go to WAIT and load cnt=MEM_LATENCY-1.
  - WAIT, cnt!=0: decrement cnt.
  - WAIT, cnt==0: return to IDLE; the access completes this cycle.
- memstall = (IDLE && MemAccessM && MEM_LATENCY!=0) || (WAIT && cnt!=0).
  - A memory instruction therefore occupies M for exactly MEM_LATENCY+1 cycles, with memstall high for MEM_LATENCY of them.
- Output equations:
  - StallF = StallD = lwstall | branchstall | memstall.
  - StallE = StallM = memstall.
  - FlushE = (lwstall | branchstall) & !memstall. During a memory freeze ID/EX holds; it is not bubbled.
  - FlushW = memstall.
  - FlushD = (PCSrcD | JumpD) & !StallD. A redirect is suppressed while decode is stalled and is taken once the stall releases.
- Back-to-back memory instructions: the next M instruction arrives in IDLE and starts a fresh wait. There is no dead cycle.
- MEM_LATENCY=0: the FSM never leaves IDLE and memstall is always 0.
- Reset asserted mid-WAIT: immediate return to IDLE with cnt=0; stalls drop asynchronously.

Optional Feature:
- Macro HAZARD_PERF_EN. When defined, add the following outputs:
  - StallCycles (32): counts cycles with StallF=1.
  - FlushCount (32): counts cycles with FlushD|FlushE=1.
  - Both reset to 0 on rst, saturate at all-ones, and update on the CLK rising edge.
- When not defined, these ports and registers are absent; the rest of the behaviour is unchanged.

Decomposition:
- Package hazard_pkg holds:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - Memory-FSM state encoding IDLE=1'b0, WAIT=1'b1.
- Sub-module mem_wait_fsm (CLK, rst, MemAccessM → memstall, MemBusy) holds the FSM and counter.
- Forwarding and stall logic stay in the top module.

Test Plan:
- Forwarding priority: RsE=5, WriteRegM=5/RegWriteM=1, WriteRegW=5/RegWriteW=1 → ForwardAE=10. Drop RegWriteM → 01. Set RsE=0 → 00.
- Load-use: MemtoRegE=1, RtE=8, RsD=8 → StallF=StallD=FlushE=1 for one cycle; StallE=0.
- Taken branch: PCSrcD=1 with no hazard → FlushD=1. Same with RegWriteE=1/WriteRegE=RsD → StallD=1, FlushD=0, then FlushD=1 the cycle after the stall drops.
- Memory wait, MEM_LATENCY=2: MemAccessM held → memstall and all Stall*/FlushW high for exactly 2 cycles, low on the 3rd; MemBusy high for 2 cycles starting the cycle after MemAccessM rises.
- Reset mid-WAIT: assert rst low while cnt=1 → all stalls 0 immediately; after release with MemAccessM=0 the FSM stays IDLE.
- HAZARD_PERF_EN: one load-use stall plus one memory wait (MEM_LATENCY=2) → StallCycles=3, FlushCount=1.

Source files
------------

// File: rtl/hazard_controller_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects
// and the data-memory wait-state FSM states.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/hazard_controller_mem_wait_fsm.sv
// Wait-state sequencer for a multi-cycle data-memory access: freezes the
// pipeline for MEM_LATENCY cycles of every access seen in the M stage.
module mem_wait_fsm #(
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 4
) (
  input  logic CLK,
  input  logic rst,
  input  logic MemAccessM,
  output logic memstall,
  output logic MemBusy
);
  import hazard_pkg::*;

  localparam bit               LAT_EN   = (MEM_LATENCY != 0);
  localparam logic [CNT_W-1:0] CNT_LOAD = (MEM_LATENCY == 0) ? '0 : CNT_W'(MEM_LATENCY - 1);

  mem_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (MemAccessM && LAT_EN) begin
            state_q <= WAIT;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
          end
        end
        WAIT: begin
          // The cnt==0 cycle is the completing cycle, so the pipeline runs then.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign memstall = ((state_q == IDLE) && MemAccessM && LAT_EN) ||
                    ((state_q == WAIT) && (cnt_q != '0));
  assign MemBusy  = busy_q;

endmodule

// File: rtl/hazard_controller.sv
// Hazard/stall scheduler for the 5-stage MIPS pipeline: forwarding, stalls,
// flushes and memory wait states. Optional counters under HAZARD_PERF_EN.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int REG_W       = 5,
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 4
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic [REG_W-1:0] WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             BranchD,
  input  logic             JumpD,
  input  logic             PCSrcD,
  input  logic             MemAccessM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemBusy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      StallCycles,
  output logic [31:0]      FlushCount
`endif
);

  logic lwstall, branchstall, memstall, stall_front;

  mem_wait_fsm #(
    .MEM_LATENCY(MEM_LATENCY),
    .CNT_W      (CNT_W)
  ) u_mem_wait (
    .CLK       (CLK),
    .rst       (rst),
    .MemAccessM(MemAccessM),
    .memstall  (memstall),
    .MemBusy   (MemBusy)
  );

  // M-stage result is younger than W-stage, so it wins when both match.
  always_comb begin
    ForwardAE = FWD_RF;
    if (RsE != '0 && RegWriteM && RsE == WriteRegM)      ForwardAE = FWD_MEM;
    else if (RsE != '0 && RegWriteW && RsE == WriteRegW) ForwardAE = FWD_WB;
    ForwardBE = FWD_RF;
    if (RtE != '0 && RegWriteM && RtE == WriteRegM)      ForwardBE = FWD_MEM;
    else if (RtE != '0 && RegWriteW && RtE == WriteRegW) ForwardBE = FWD_WB;
  end

  assign ForwardAD = (RsD != '0) && RegWriteM && (RsD == WriteRegM);
  assign ForwardBD = (RtD != '0) && RegWriteM && (RtD == WriteRegM);

  assign lwstall     = MemtoRegE && ((RtE == RsD) || (RtE == RtD));
  assign branchstall = BranchD &&
                       ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                        (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));

  assign stall_front = lwstall | branchstall | memstall;
  assign StallF = stall_front;
  assign StallD = stall_front;
  assign StallE = memstall;
  assign StallM = memstall;
  // A frozen ID/EX must keep its contents rather than take a bubble.
  assign FlushE = (lwstall | branchstall) & ~memstall;
  assign FlushW = memstall;
  assign FlushD = (PCSrcD | JumpD) & ~stall_front;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (StallF && stall_cycles_q != '1)          stall_cycles_q <= stall_cycles_q + 32'd1;
      if ((FlushD | FlushE) && flush_count_q != '1) flush_count_q  <= flush_count_q + 32'd1;
    end
  end

  assign StallCycles = stall_cycles_q;
  assign FlushCount  = flush_count_q;
`endif

endmodule
